// File: rtl/counter_sched.sv
`default_nettype none
// ============================================================================
// Module   : counter_sched
// Purpose  : Shares one WIDTH-bit up-counter between two requesters.
//            Requests are arbitrated round-robin. The winner's interval
//            length is loaded, and the counter runs from 1 up to that
//            length. The winner then receives a one-cycle done pulse.
//            Withdrawal of the winner's request ends the interval without
//            a done pulse. A global abort also ends it without a done pulse.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-low clear of all state
//            req    - level requests, one per requester
//            len0   - interval length for requester 0 (sampled in GRANT)
//            len1   - interval length for requester 1 (sampled in GRANT)
//            abort  - synchronous abort of the current interval
//            gnt    - one-hot grant, high through GRANT/RUN/DONE
//            done   - one-cycle completion pulse to the granted requester
//            busy   - high whenever the scheduler is not idle
//            count  - current counter value
// Revision : 1.0 - initial release
// ============================================================================
module counter_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             abort,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             win_q,   win_d;     // requester currently being served
    logic             ptr_q,   ptr_d;     // last-served requester
    logic [WIDTH-1:0] len_q,   len_d;
    logic [WIDTH-1:0] count_q, count_d;

    logic [1:0]       w_win_oh;
    logic             w_req_win;
    logic [WIDTH-1:0] w_len_sel;

    always_comb begin
        w_win_oh  = win_q ? 2'b10 : 2'b01;
        w_req_win = req[win_q];
        w_len_sel = win_q ? len1 : len0;
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        count_d = count_q;
        gnt     = 2'b00;
        done    = 2'b00;

        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (req != 2'b00) begin
                    state_d = S_GRANT;
                    // On a tie, the requester that was not served last wins.
                    win_d   = (req == 2'b11) ? ~ptr_q : req[1];
                end
            end

            S_GRANT: begin
                gnt   = w_win_oh;
                len_d = w_len_sel;
                // The pointer moves on grant. A later withdrawal or abort
                // still counts as having been served.
                ptr_d = win_q;
                if (abort || !w_req_win) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (w_len_sel == '0) begin
                    state_d = S_DONE;
                    count_d = '0;
                end else begin
                    state_d = S_RUN;
                    count_d = WIDTH'(1);
                end
            end

            S_RUN: begin
                gnt = w_win_oh;
                if (abort || !w_req_win) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (count_q == len_q) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end

            S_DONE: begin
                gnt = w_win_oh;
                // An abort arriving in the DONE cycle kills the pulse itself.
                if (!abort) begin
                    done = w_win_oh;
                end
                state_d = S_IDLE;
                count_d = '0;
            end

            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            win_q   <= 1'b0;
            ptr_q   <= 1'b1;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            count_q <= count_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_sched
// Purpose  : Self-checking bench for counter_sched. An interval-level model
//            predicts gnt/done/busy/count each cycle. Directed scenarios
//            provide literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_sched;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   req   = 2'b00;
    logic [W-1:0] len0  = '0;
    logic [W-1:0] len1  = '0;
    logic         abort = 1'b0;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         busy;
    logic [W-1:0] count;

    counter_sched #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .abort (abort),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Interval model: an interval is active from grant until it ends.
    // e counts the cycles since grant. The counter shows min(e, len).
    // Completion happens at e == len+1.
    bit m_act;
    bit m_win;
    int m_e;
    int m_len;
    bit m_ptr;

    always @(posedge clk or negedge reset) begin : model
        int L;
        if (!reset) begin
            m_act = 0; m_win = 0; m_e = 0; m_len = 0; m_ptr = 1;
        end else if (!m_act) begin
            if (req != 2'b00) begin
                m_act = 1;
                m_e   = 0;
                m_win = (req == 2'b11) ? !m_ptr : req[1];
            end
        end else begin
            L = (m_e == 0) ? int'(m_win ? len1 : len0) : m_len;
            if (m_e == 0) begin
                m_len = L;
                m_ptr = m_win;
            end
            if (abort)                      m_act = 0;
            else if (m_e <= L && !req[m_win]) m_act = 0;
            else if (m_e == L + 1)          m_act = 0;
            else                            m_e++;
        end
    end

    always @(negedge clk) begin : compare
        int eg, ed, ec;
        if (reset) begin
            eg = m_act ? (m_win ? 2 : 1) : 0;
            ed = (m_act && m_e == m_len + 1 && !abort) ? eg : 0;
            ec = !m_act ? 0 : ((m_e < m_len) ? m_e : m_len);
            chk("model_gnt",   int'(gnt),   eg);
            chk("model_done",  int'(done),  ed);
            chk("model_busy",  int'(busy),  m_act ? 1 : 0);
            chk("model_count", int'(count), ec);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin : stim
        int n;

        // Reset state
        step(1);
        chk("rst_gnt",   int'(gnt),   0);
        chk("rst_done",  int'(done),  0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_count", int'(count), 0);

        // Single request, len0=5
        reset = 1'b1; req = 2'b01; len0 = 8'd5;
        step(1);
        chk("t1_gnt", int'(gnt), 1);
        chk("t1_cnt0", int'(count), 0);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk("t1_cnt", int'(count), i);
            chk("t1_nodone", int'(done), 0);
        end
        step(1);
        chk("t1_done", int'(done), 1);
        chk("t1_cnt_hold", int'(count), 5);
        req = 2'b00;
        step(1);
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_idle_cnt", int'(count), 0);

        // Both request from reset: requester 0 first, then requester 1
        do_reset();
        len0 = 8'd2; len1 = 8'd3; req = 2'b11;
        step(1);
        chk("t2_gnt0", int'(gnt), 1);
        step(3);
        chk("t2_done0", int'(done), 1);
        step(1);
        chk("t2_gap_gnt", int'(gnt), 0);
        chk("t2_gap_busy", int'(busy), 0);
        step(1);
        chk("t2_gnt1", int'(gnt), 2);
        step(3);
        chk("t2_cnt3", int'(count), 3);
        step(1);
        chk("t2_done1", int'(done), 2);
        req = 2'b01;
        step(2);
        chk("t2_regrant0", int'(gnt), 1);
        req = 2'b00;
        step(2);

        // Zero length interval on requester 1
        req = 2'b10; len1 = 8'd0;
        step(1);
        chk("t3_gnt", int'(gnt), 2);
        step(1);
        chk("t3_done", int'(done), 2);
        chk("t3_cnt", int'(count), 0);
        req = 2'b00;
        step(2);

        // Maximum length: no wrap, done 256 cycles after grant
        req = 2'b01; len0 = 8'd255;
        step(1);
        chk("t4_gnt", int'(gnt), 1);
        n = 0;
        while (n <= 300) begin
            step(1);
            n++;
            if (done != 2'b00) break;
        end
        chk("t4_latency", n, 256);
        chk("t4_cnt", int'(count), 255);
        req = 2'b00;
        step(2);

        // Withdrawal at count 4
        req = 2'b01; len0 = 8'd10;
        step(5);
        chk("t5_cnt4", int'(count), 4);
        req = 2'b00;
        step(1);
        chk("t5_wd_busy", int'(busy), 0);
        chk("t5_wd_cnt", int'(count), 0);

        // Abort at count 7
        req = 2'b01;
        step(8);
        chk("t5_cnt7", int'(count), 7);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t5_ab_busy", int'(busy), 0);
        chk("t5_ab_cnt", int'(count), 0);
        chk("t5_ab_done", int'(done), 0);
        req = 2'b00;
        step(2);

        // Abort during DONE suppresses the pulse
        req = 2'b01; len0 = 8'd1;
        step(3);
        abort = 1'b1;
        #1;
        chk("t5_dn_gnt", int'(gnt), 1);
        chk("t5_dn_done", int'(done), 0);
        step(1);
        abort = 1'b0; req = 2'b00;
        chk("t5_dn_idle", int'(busy), 0);
        step(1);

        // Asynchronous reset mid-run
        req = 2'b01; len0 = 8'd10;
        step(4);
        chk("t6_cnt3", int'(count), 3);
        #2 reset = 1'b0;
        #1;
        chk("t6_gnt", int'(gnt), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_cnt", int'(count), 0);
        req = 2'b11; len0 = 8'd1; len1 = 8'd1;
        step(1);
        reset = 1'b1;
        step(1);
        chk("t6_gnt0", int'(gnt), 1);
        req = 2'b00;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
